seq_restoring_divider: RTL and testbench

//  Multi-cycle unsigned integer divider, the inverse datapath of the team's combinational 16-bit

---
 rtl/div_pkg.sv | 13 +
 rtl/restore_step.sv | 22 ++
 rtl/seq_restoring_divider.sv | 136 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default sizing.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/restore_step.sv
// One restoring shift-subtract step: brings in the next dividend bit and
// subtracts the divisor when it fits.
module restore_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  always_comb begin
    // Extra MSB acts as the borrow flag of the trial subtraction.
    trial   = {rem_in, dvd_bit} - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], dvd_bit};
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned divider, one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             res_valid_q, res_valid_d;
  logic             start_ready_q, start_ready_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (quo_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    dbz_d         = dbz_q;
    res_valid_d   = res_valid_q;
    start_ready_d = start_ready_q;

    unique case (state_q)
      IDLE: begin
        start_ready_d = 1'b1;
        res_valid_d   = 1'b0;
        if (start_valid && start_ready_q) begin
          start_ready_d = 1'b0;
          dbz_d         = 1'b0;
          rem_d         = '0;
          quo_d         = dividend;
          dvs_d         = divisor;
          cnt_d         = '0;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          quotient_d  = {quo_q[WIDTH-2:0], step_q};
          remainder_d = step_rem;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d   = 1'b0;
          start_ready_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d       = IDLE;
        res_valid_d   = 1'b0;
        start_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      dbz_q         <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      dbz_q         <= dbz_d;
      res_valid_q   <= res_valid_d;
      start_ready_q <= start_ready_d;
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, backpressure, reset abort, random traffic.
module tb_seq_restoring_divider;

  localparam int unsigned W  = 16;
  localparam int unsigned NR = 2000;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for start_ready (bounded), then presents one request for exactly one edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned g = 0;
    while (!start_ready && g < 64) begin
      step();
      g++;
    end
    if (!start_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_wait: start_ready=%0b required 1 within 64 cycles", start_ready);
    end
    dividend    = a;
    divisor     = b;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until res_valid is seen (capped at 64).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 64) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_vec++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || quotient !== '0 ||
        remainder !== '0 || div_by_zero !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_in: rv=%0b sr=%0b q=%0h r=%0h z=%0b required rv=0 sr=1 q=0 r=0 z=0",
               res_valid, start_ready, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || quotient !== '0 ||
        remainder !== '0 || div_by_zero !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_out: rv=%0b sr=%0b q=%0h r=%0h z=%0b required rv=0 sr=1 q=0 r=0 z=0",
               res_valid, start_ready, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6];
    logic [W-1:0] tb [6];
    int           lat;
    int           exp_lat;
    exp_t         e;
    ta = '{16'd100, 16'd1234, 16'hFFFF, 16'd5, 16'd0, 16'd65535};
    tb = '{16'd7,   16'd0,    16'd1,    16'd9, 16'd3, 16'd65535};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model(ta[i], tb[i]));
      send(ta[i], tb[i]);
      wait_result(lat);
      // A zero divisor finishes on the accept edge itself; otherwise one edge per bit.
      exp_lat = (tb[i] == '0) ? 0 : W;
      n_vec++;
      if (lat !== exp_lat) begin
        n_miss++;
        $display("FAIL latency %0d/%0d: got %0d edges required %0d", ta[i], tb[i], lat, exp_lat);
      end
      e = sb.pop_front();
      n_vec++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
        n_miss++;
        $display("FAIL result %0d/%0d: q=%0d r=%0d z=%0b required q=%0d r=%0d z=%0b",
                 ta[i], tb[i], quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    sb.push_back(model(16'd1000, 16'd33));
    send(16'd1000, 16'd33);
    wait_result(lat);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1;
      dividend    = 16'($urandom);
      divisor     = 16'd1;
      step();
      n_vec++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || quotient !== e.q ||
          remainder !== e.r || div_by_zero !== e.z) begin
        n_miss++;
        $display("FAIL hold_%0d: rv=%0b sr=%0b q=%0d r=%0d z=%0b required rv=1 sr=0 q=%0d r=%0d z=%0b",
                 i, res_valid, start_ready, quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    step();
    res_ready = 1'b0;
    n_vec++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || quotient !== e.q || remainder !== e.r) begin
      n_miss++;
      $display("FAIL drain: rv=%0b sr=%0b q=%0d r=%0d required rv=0 sr=1 q=%0d r=%0d",
               res_valid, start_ready, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    exp_t e;
    send(16'd50000, 16'd7);
    for (int i = 0; i < 8; i++) step();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || quotient !== '0 ||
        remainder !== '0 || div_by_zero !== 1'b0) begin
      n_miss++;
      $display("FAIL abort: rv=%0b sr=%0b q=%0h r=%0h z=%0b required rv=0 sr=1 q=0 r=0 z=0",
               res_valid, start_ready, quotient, remainder, div_by_zero);
    end
    step();
    rst_n = 1'b1;
    step();
    sb.push_back(model(16'd40000, 16'd300));
    send(16'd40000, 16'd300);
    wait_result(lat);
    e = sb.pop_front();
    n_vec++;
    if (lat !== W || quotient !== 16'd133 || remainder !== 16'd100 ||
        quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
      n_miss++;
      $display("FAIL after_abort: lat=%0d q=%0d r=%0d z=%0b required lat=%0d q=133 r=100 z=0",
               lat, quotient, remainder, div_by_zero, W);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    int issued  = 0;
    int drained = 0;
    fork
      begin : driver
        int unsigned cyc = 0;
        logic [W-1:0] a, b;
        while (issued < NR && cyc < NR * 30) begin
          if (start_ready && $urandom_range(0, 3) != 0) begin
            a = 16'($urandom);
            if ($urandom_range(0, 9) == 0) b = '0;
            else if ($urandom_range(0, 1) == 0) b = 16'($urandom_range(1, 255));
            else b = 16'($urandom_range(1, 65535));
            sb.push_back(model(a, b));
            dividend    = a;
            divisor     = b;
            start_valid = 1'b1;
            step();
            start_valid = 1'b0;
            issued++;
          end else begin
            step();
          end
          cyc++;
        end
      end
      begin : monitor
        int unsigned cyc = 0;
        exp_t e;
        while (drained < NR && cyc < NR * 30) begin
          res_ready = ($urandom_range(0, 2) != 0);
          if (res_valid && res_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
              n_miss++;
              $display("FAIL rand_extra: result q=%0d r=%0d with empty scoreboard", quotient, remainder);
            end else begin
              e = sb.pop_front();
              if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
                n_miss++;
                $display("FAIL rand_%0d: q=%0d r=%0d z=%0b required q=%0d r=%0d z=%0b",
                         drained, quotient, remainder, div_by_zero, e.q, e.r, e.z);
              end
            end
            drained++;
          end
          step();
          cyc++;
        end
        res_ready = 1'b0;
      end
    join
    n_vec++;
    if (drained !== NR || issued !== NR || sb.size() !== 0) begin
      n_miss++;
      $display("FAIL rand_count: issued=%0d drained=%0d pending=%0d required %0d/%0d/0",
               issued, drained, sb.size(), NR, NR);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
